// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: runs one request/addr_ok/data_ok bus transaction
// per load or store and holds M until that transaction completes.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        respon,
    input  logic        M_valid,
    input  logic        MemWriteM,
    input  logic        MemOrALUM,
    input  logic        EXLM,
    input  logic [1:0]  MemInSelM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] rd2M,
    input  logic        W_allowin,
    output logic        M_allowin,
    output logic        M_to_W_valid,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdataM
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_rdata;
    logic        w_memop;
    logic        w_ready_go;
    logic        w_capture;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_strb(input logic [1:0] sel, input logic [1:0] off);
        logic [3:0] strb;
        case (sel)
            2'b01:   strb = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   strb = 4'b0001 << off;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    assign w_memop      = M_valid & (MemWriteM | MemOrALUM) & ~EXLM;
    assign w_ready_go   = ~w_memop | (r_state == ST_DONE);
    assign M_allowin    = ~M_valid | (w_ready_go & W_allowin);
    assign M_to_W_valid = M_valid & w_ready_go & ~respon;
    assign data_req     = (r_state == ST_ADDR);
    assign rdataM       = r_rdata;
    assign w_capture    = (r_state == ST_DATA) & data_data_ok & ~respon & MemOrALUM;

    // Next-state logic; a flush never abandons an accepted request without draining it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_memop && !respon) w_state_nxt = ST_ADDR;
                else                    w_state_nxt = ST_IDLE;
            end
            ST_ADDR: begin
                if (respon)            w_state_nxt = data_addr_ok ? ST_DISCARD : ST_IDLE;
                else if (data_addr_ok) w_state_nxt = ST_DATA;
                else                   w_state_nxt = ST_ADDR;
            end
            ST_DATA: begin
                if (data_data_ok) w_state_nxt = respon ? ST_IDLE : ST_DONE;
                else if (respon)  w_state_nxt = ST_DISCARD;
                else              w_state_nxt = ST_DATA;
            end
            ST_DONE: begin
                if (W_allowin || respon) w_state_nxt = ST_IDLE;
                else                     w_state_nxt = ST_DONE;
            end
            ST_DISCARD: begin
                if (data_data_ok) w_state_nxt = ST_IDLE;
                else              w_state_nxt = ST_DISCARD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and load-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) r_rdata <= data_rdata;
        end
    end

    // Bus command fields, derived directly from the held M-stage operands.
    always_comb begin
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = {ALUoutM[31:2], 2'b00};
        data_wdata = 32'd0;
        data_wstrb = 4'b0000;
        if (MemWriteM) begin
            data_wr    = 1'b1;
            data_addr  = ALUoutM;
            data_wstrb = store_strb(MemInSelM, ALUoutM[1:0]);
            case (MemInSelM)
                2'b01: begin
                    data_size  = 2'd1;
                    data_wdata = {2{rd2M[15:0]}};
                end
                2'b10: begin
                    data_size  = 2'd0;
                    data_wdata = {4{rd2M[7:0]}};
                end
                default: begin
                    data_size  = 2'd2;
                    data_wdata = rd2M;
                end
            endcase
        end else begin
            data_wr = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a vector table for the combinational bus/handshake
// decode, then hand-timed sequences for delays, flushes and back-pressure.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        respon;
    logic        M_valid;
    logic        MemWriteM;
    logic        MemOrALUM;
    logic        EXLM;
    logic [1:0]  MemInSelM;
    logic [31:0] ALUoutM;
    logic [31:0] rd2M;
    logic        W_allowin;
    logic        M_allowin;
    logic        M_to_W_valid;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] rdataM;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        valid, st, ld, exl, rsp, wal;
        logic [1:0]  sel;
        logic [31:0] addr, rd2;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_strb;
        logic        e_allow, e_mtow;
    } vec_t;

    vec_t vecs[14];

    mem_access_ctrl dut (
        .clk(clk), .reset(reset), .respon(respon), .M_valid(M_valid),
        .MemWriteM(MemWriteM), .MemOrALUM(MemOrALUM), .EXLM(EXLM),
        .MemInSelM(MemInSelM), .ALUoutM(ALUoutM), .rd2M(rd2M),
        .W_allowin(W_allowin), .M_allowin(M_allowin), .M_to_W_valid(M_to_W_valid),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .rdataM(rdataM)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    initial begin
        reset = 1'b1; respon = 1'b0; M_valid = 1'b0; MemWriteM = 1'b0; MemOrALUM = 1'b0;
        EXLM = 1'b0; MemInSelM = 2'b00; ALUoutM = 32'd0; rd2M = 32'd0; W_allowin = 1'b1;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;

        //            valid st    ld    exl   rsp   wal   sel    addr          rd2           wr    size  e_addr        e_wdata       strb     allow mtow
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_1006, 32'h0000_0000, 1'b0, 2'd2, 32'h0000_1004, 32'h0000_0000, 4'b0000, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_2003, 32'h1234_56AB, 1'b1, 2'd0, 32'h0000_2003, 32'hABAB_ABAB, 4'b1000, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_2000, 32'h0000_00C3, 1'b1, 2'd0, 32'h0000_2000, 32'hC3C3_C3C3, 4'b0001, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_2001, 32'hFFFF_FF5A, 1'b1, 2'd0, 32'h0000_2001, 32'h5A5A_5A5A, 4'b0010, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_3002, 32'hCAFE_BEEF, 1'b1, 2'd1, 32'h0000_3002, 32'hBEEF_BEEF, 4'b1100, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_3001, 32'h0000_1234, 1'b1, 2'd1, 32'h0000_3001, 32'h1234_1234, 4'b0011, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_4004, 32'h0102_0304, 1'b1, 2'd2, 32'h0000_4004, 32'h0102_0304, 4'b1111, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h0000_4008, 32'h89AB_CDEF, 1'b1, 2'd2, 32'h0000_4008, 32'h89AB_CDEF, 4'b1111, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_5007, 32'h0000_0000, 1'b0, 2'd2, 32'h0000_5004, 32'h0000_0000, 4'b0000, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_5007, 32'h0000_0000, 1'b0, 2'd2, 32'h0000_5004, 32'h0000_0000, 4'b0000, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_600B, 32'h0000_0000, 1'b0, 2'd2, 32'h0000_6008, 32'h0000_0000, 4'b0000, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_7000, 32'h0000_0000, 1'b0, 2'd2, 32'h0000_7000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_7000, 32'h0000_0000, 1'b0, 2'd2, 32'h0000_7000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_2002, 32'h0000_0077, 1'b1, 2'd0, 32'h0000_2002, 32'h7777_7777, 4'b0100, 1'b0, 1'b1};

        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst req", data_req, 32'd0);
        check("rst rdataM", rdataM, 32'd0);
        check("rst allowin", M_allowin, 32'd1);
        check("rst mtow", M_to_W_valid, 32'd0);
        tick();

        for (int i = 0; i < 14; i++) begin
            M_valid = vecs[i].valid; MemWriteM = vecs[i].st; MemOrALUM = vecs[i].ld;
            EXLM = vecs[i].exl; respon = vecs[i].rsp; W_allowin = vecs[i].wal;
            MemInSelM = vecs[i].sel; ALUoutM = vecs[i].addr; rd2M = vecs[i].rd2;
            #1;
            check($sformatf("v%0d req", i), data_req, 32'd0);
            check($sformatf("v%0d wr", i), data_wr, vecs[i].e_wr);
            check($sformatf("v%0d size", i), data_size, vecs[i].e_size);
            check($sformatf("v%0d addr", i), data_addr, vecs[i].e_addr);
            check($sformatf("v%0d wdata", i), data_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d wstrb", i), data_wstrb, vecs[i].e_strb);
            check($sformatf("v%0d allowin", i), M_allowin, vecs[i].e_allow);
            check($sformatf("v%0d mtow", i), M_to_W_valid, vecs[i].e_mtow);
            tick();
        end
        M_valid = 1'b0; MemWriteM = 1'b0; MemOrALUM = 1'b0; EXLM = 1'b0;
        respon = 1'b0; W_allowin = 1'b1; MemInSelM = 2'b00;
        tick();

        // load word, zero-delay bus
        M_valid = 1'b1; MemOrALUM = 1'b1; ALUoutM = 32'h0000_1006;
        #1; check("A0 req", data_req, 32'd0); check("A0 allowin", M_allowin, 32'd0); tick();
        data_addr_ok = 1'b1;
        #1; check("A1 req", data_req, 32'd1); check("A1 addr", data_addr, 32'h0000_1004);
        check("A1 wstrb", data_wstrb, 32'd0); tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1; check("A2 req", data_req, 32'd0); check("A2 mtow", M_to_W_valid, 32'd0); tick();
        data_data_ok = 1'b0;
        #1; check("A3 mtow", M_to_W_valid, 32'd1); check("A3 allowin", M_allowin, 32'd1);
        check("A3 rdataM", rdataM, 32'hDEAD_BEEF); tick();
        M_valid = 1'b0; MemOrALUM = 1'b0;
        tick();

        // half store, addr_ok on the 4th request cycle, data_ok one cycle later than minimum
        M_valid = 1'b1; MemWriteM = 1'b1; MemInSelM = 2'b01; ALUoutM = 32'h0000_3002;
        rd2M = 32'hCAFE_BEEF; data_rdata = 32'h1111_1111;
        for (int c = 0; c < 8; c++) begin
            data_addr_ok = (c == 4);
            data_data_ok = (c == 6);
            #1;
            check($sformatf("B%0d req", c), data_req, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            check($sformatf("B%0d mtow", c), M_to_W_valid, (c == 7) ? 32'd1 : 32'd0);
            check($sformatf("B%0d allowin", c), M_allowin, (c == 7) ? 32'd1 : 32'd0);
            if (c == 1) check("B1 wstrb", data_wstrb, 32'hC);
            tick();
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0; M_valid = 1'b0; MemWriteM = 1'b0;
        MemInSelM = 2'b00;
        #1; check("B store keeps rdataM", rdataM, 32'hDEAD_BEEF);
        tick();

        // flush in DATA, stale response drained, then W back-pressure in DONE
        M_valid = 1'b1; MemOrALUM = 1'b1; ALUoutM = 32'h0000_6000; tick();
        data_addr_ok = 1'b1;
        #1; check("C1 req", data_req, 32'd1); tick();
        data_addr_ok = 1'b0; respon = 1'b1;
        #1; check("C2 mtow", M_to_W_valid, 32'd0); check("C2 req", data_req, 32'd0); tick();
        respon = 1'b0; ALUoutM = 32'h0000_7000;
        #1; check("C3 req", data_req, 32'd0); check("C3 allowin", M_allowin, 32'd0);
        check("C3 mtow", M_to_W_valid, 32'd0); tick();
        data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
        #1; check("C4 req", data_req, 32'd0); tick();
        data_data_ok = 1'b0;
        #1; check("C5 req", data_req, 32'd0); check("C5 rdataM", rdataM, 32'hDEAD_BEEF); tick();
        data_addr_ok = 1'b1;
        #1; check("C6 req", data_req, 32'd1); check("C6 addr", data_addr, 32'h0000_7000); tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D; tick();
        data_data_ok = 1'b0; W_allowin = 1'b0;
        #1; check("D0 mtow", M_to_W_valid, 32'd1); check("D0 allowin", M_allowin, 32'd0);
        check("D0 rdataM", rdataM, 32'h0BAD_F00D); tick();
        #1; check("D1 mtow", M_to_W_valid, 32'd1); check("D1 allowin", M_allowin, 32'd0);
        check("D1 req", data_req, 32'd0); tick();
        W_allowin = 1'b1;
        #1; check("D2 allowin", M_allowin, 32'd1); check("D2 mtow", M_to_W_valid, 32'd1); tick();
        M_valid = 1'b0; MemOrALUM = 1'b0;
        tick();

        // EXLM load, then flush coincident with addr_ok
        M_valid = 1'b1; MemOrALUM = 1'b1; EXLM = 1'b1; ALUoutM = 32'h0000_9000;
        #1; check("E exl mtow", M_to_W_valid, 32'd1); check("E exl req", data_req, 32'd0);
        check("E exl allowin", M_allowin, 32'd1); tick();
        EXLM = 1'b0; ALUoutM = 32'h0000_8000;
        #1; check("E0 req", data_req, 32'd0); tick();
        respon = 1'b1; data_addr_ok = 1'b1;
        #1; check("E1 req", data_req, 32'd1); check("E1 mtow", M_to_W_valid, 32'd0); tick();
        respon = 1'b0; data_addr_ok = 1'b0; M_valid = 1'b0; MemOrALUM = 1'b0;
        #1; check("E2 req", data_req, 32'd0); tick();
        data_data_ok = 1'b1; data_rdata = 32'h6666_6666;
        #1; check("E3 req", data_req, 32'd0); tick();
        data_data_ok = 1'b0; M_valid = 1'b1; MemOrALUM = 1'b1; ALUoutM = 32'h0000_A000;
        #1; check("E4 req", data_req, 32'd0); check("E4 rdataM", rdataM, 32'h0BAD_F00D); tick();
        data_addr_ok = 1'b1;
        #1; check("E5 req", data_req, 32'd1); tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1357_9BDF; tick();
        data_data_ok = 1'b0;
        #1; check("E7 mtow", M_to_W_valid, 32'd1); check("E7 rdataM", rdataM, 32'h1357_9BDF); tick();
        M_valid = 1'b0; MemOrALUM = 1'b0;
        tick();

        // flush in ADDR without addr_ok withdraws the request; reset in ADDR forces IDLE
        M_valid = 1'b1; MemOrALUM = 1'b1; ALUoutM = 32'h0000_B000; tick();
        respon = 1'b1;
        #1; check("F1 req", data_req, 32'd1); tick();
        respon = 1'b0; M_valid = 1'b0;
        #1; check("F2 req", data_req, 32'd0); tick();
        M_valid = 1'b1;
        #1; check("F3 req", data_req, 32'd0); tick();
        #1; check("F4 req", data_req, 32'd1);
        reset = 1'b1; tick();
        reset = 1'b0; M_valid = 1'b0; MemOrALUM = 1'b0;
        #1; check("F5 req", data_req, 32'd0); check("F5 rdataM", rdataM, 32'd0);
        check("F5 allowin", M_allowin, 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
